muldiv_hilo_ctrl: RTL and testbench

Sequencing controller between the MIPS decode/execute stage and the 32-cycle iterative unsigned multiplier core. It accepts MULT/MULTU/MFHI/MFLO/MTHI/MTLO operations and launches the core. For signed MULT it applies operand and result sign correction. It owns the architectural HI/LO registers and stalls the pipeline on any HI/LO hazard while a multiply is in flight.

---
 rtl/muldiv_hilo_ctrl.sv | 159 +++++++++++++++
 tb/tb_muldiv_hilo_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_hilo_ctrl.sv
// muldiv_hilo_ctrl
// Sequencing controller between MIPS decode/execute and the 32-cycle iterative
// unsigned multiplier core. Owns the architectural HI/LO registers, launches
// the core for MULT/MULTU and stalls any HI/LO access while a multiply is in
// flight.
//
// Build option: define MULDIV_SIGNED_EN to give MULT signed semantics (operand
// magnitudes go to the core, and the product is negated when the operand signs
// differ). Without it, MULT behaves exactly like MULTU.
//
// state  | meaning
// IDLE   | accepting ops; MTHI/MTLO write here, MFHI/MFLO read here
// LAUNCH | core_start pulse toward the core
// WAIT   | core iterating; leave once core_busy drops
// WRITE  | done pulse; HI/LO take the (sign-corrected) product on exit

module muldiv_hilo_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic [2:0]  op,
  input  logic        op_valid,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        op_ready,
  output logic        stall,
  output logic [31:0] rdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        done,
  output logic [31:0] core_a,
  output logic [31:0] core_b,
  output logic        core_start,
  input  logic [63:0] core_result,
  input  logic        core_busy
);

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_MFHI  = 3'd3;
  localparam logic [2:0] OP_MFLO  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    WRITE  = 2'd3
  } state_t;

  state_t      state;
  logic        accept;
  logic        is_mul;
  logic        is_real_op;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [63:0] product;

  assign op_ready   = (state == IDLE);
  assign accept     = op_valid & op_ready;
  assign is_mul     = (op == OP_MULT) | (op == OP_MULTU);
  // NONE and the reserved encoding never interact with HI/LO, so they never stall.
  assign is_real_op = (op != OP_NONE) & (op != 3'd7);
  assign stall      = op_valid & is_real_op & ~op_ready;

`ifdef MULDIV_SIGNED_EN
  logic neg;
  logic neg_next;
  logic signed_op;

  // Magnitudes for the unsigned core; 0x80000000 negates to itself, which is
  // the correct magnitude when read as unsigned.
  always_comb begin
    signed_op = (op == OP_MULT);
    mag_a     = rs;
    mag_b     = rt;
    neg_next  = 1'b0;
    if (signed_op) begin
      if (rs[31]) mag_a = ~rs + 32'd1;
      if (rt[31]) mag_b = ~rt + 32'd1;
      neg_next = rs[31] ^ rt[31];
    end
    product = neg ? (~core_result + 64'd1) : core_result;
  end
`else
  // Unsigned-only build: MULT decodes exactly like MULTU.
  always_comb begin
    mag_a   = rs;
    mag_b   = rt;
    product = core_result;
  end
`endif

  // Read port for MFHI/MFLO; returns the register value as of this cycle.
  always_comb begin
    rdata = 32'd0;
    if (op == OP_MFHI) rdata = hi;
    else if (op == OP_MFLO) rdata = lo;
  end

  // Sequencer with registered core handshake, done pulse and HI/LO ownership.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state      <= IDLE;
      hi         <= 32'd0;
      lo         <= 32'd0;
      core_a     <= 32'd0;
      core_b     <= 32'd0;
      core_start <= 1'b0;
      done       <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      neg        <= 1'b0;
`endif
    end else begin
      core_start <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_mul) begin
              core_a     <= mag_a;
              core_b     <= mag_b;
              core_start <= 1'b1;
`ifdef MULDIV_SIGNED_EN
              neg        <= neg_next;
`endif
              state      <= LAUNCH;
            end else if (op == OP_MTHI) begin
              hi <= rs;
            end else if (op == OP_MTLO) begin
              lo <= rs;
            end
          end
        end
        LAUNCH: begin
          state <= WAIT;
        end
        // core_busy is already high in the first WAIT cycle, so a low level
        // here always means the product is ready.
        WAIT: begin
          if (!core_busy) begin
            done  <= 1'b1;
            state <= WRITE;
          end
        end
        WRITE: begin
          hi    <= product[63:32];
          lo    <= product[31:0];
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Bench for muldiv_hilo_ctrl with a behavioural 32-cycle multiplier core.
// Expected HI/LO products go into a scoreboard queue when a multiply is issued
// and are popped once the controller writes back.
// Honours MULDIV_SIGNED_EN the same way the design does.

module tb_muldiv_hilo_ctrl;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_MFHI  = 3'd3;
  localparam logic [2:0] OP_MFLO  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic        clk;
  logic        resetn;
  logic [2:0]  op;
  logic        op_valid;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        op_ready;
  logic        stall;
  logic [31:0] rdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        done;
  logic [31:0] core_a;
  logic [31:0] core_b;
  logic        core_start;
  logic [63:0] core_result;
  logic        core_busy;

  int passed = 0;
  int total  = 0;
  logic [63:0] sb[$];

  muldiv_hilo_ctrl dut (
    .clk         (clk),
    .resetn      (resetn),
    .op          (op),
    .op_valid    (op_valid),
    .rs          (rs),
    .rt          (rt),
    .op_ready    (op_ready),
    .stall       (stall),
    .rdata       (rdata),
    .hi          (hi),
    .lo          (lo),
    .done        (done),
    .core_a      (core_a),
    .core_b      (core_b),
    .core_start  (core_start),
    .core_result (core_result),
    .core_busy   (core_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core model: captures start, busy for 32 edges (falls on the 32nd edge after capture).
  int core_cnt;
  always @(posedge clk or posedge resetn) begin
    if (resetn) begin
      core_busy   <= 1'b0;
      core_cnt    <= 0;
      core_result <= 64'd0;
    end else if (core_start) begin
      core_busy   <= 1'b1;
      core_cnt    <= 31;
      core_result <= {32'd0, core_a} * {32'd0, core_b};
    end else if (core_busy) begin
      if (core_cnt == 0) core_busy <= 1'b0;
      else core_cnt <= core_cnt - 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic bit signed_mult(input logic [2:0] mop);
`ifdef MULDIV_SIGNED_EN
    return mop == OP_MULT;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [63:0] model_product(input logic [2:0] mop, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb_;
    if (signed_mult(mop)) begin
      sa  = {{32{a[31]}}, a};
      sb_ = {{32{b[31]}}, b};
      return sa * sb_;
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  function automatic logic [31:0] model_mag(input logic [2:0] mop, input logic [31:0] v);
    if (signed_mult(mop) && v[31]) return 32'd0 - v;
    return v;
  endfunction

  // Issue a multiply, optionally follow it with an MFHI that must stall until IDLE.
  task automatic run_mul(input string tag, input logic [2:0] mop, input logic [31:0] a,
                         input logic [31:0] b, input bit follow);
    logic [63:0] exp;
    int cyc;
    int stalls;
    @(negedge clk);
    op = mop; op_valid = 1'b1; rs = a; rt = b;
    #1;
    check({tag, "_ready"}, {63'd0, op_ready}, 64'd1);
    sb.push_back(model_product(mop, a, b));
    @(posedge clk); #1;
    check({tag, "_start"}, {63'd0, core_start}, 64'd1);
    check({tag, "_core_ab"}, {core_a, core_b}, {model_mag(mop, a), model_mag(mop, b)});
    if (follow) begin op = OP_MFHI; op_valid = 1'b1; end
    else begin op = OP_NONE; op_valid = 1'b0; end
    #1;
    stalls = stall ? 1 : 0;
    cyc = 0;
    while (!done && cyc < 100) begin
      @(posedge clk); cyc++; #1;
      if (stall) stalls++;
    end
    check({tag, "_done_edge"}, 64'(cyc), 64'd34);
    @(posedge clk); #1;
    exp = (sb.size() != 0) ? sb.pop_front() : 64'hx;
    check({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
    check({tag, "_ready_after"}, {63'd0, op_ready}, 64'd1);
    check({tag, "_hilo"}, {hi, lo}, exp);
    if (follow) begin
      check({tag, "_stall_cycles"}, 64'(stalls), 64'd35);
      check({tag, "_stall_released"}, {63'd0, stall}, 64'd0);
      check({tag, "_mfhi_rdata"}, {32'd0, rdata}, {32'd0, exp[63:32]});
    end
    @(negedge clk);
    op = OP_NONE; op_valid = 1'b0;
  endtask

  initial begin
    int done_pulses;
    resetn = 1'b1; op = OP_MULTU; op_valid = 1'b1; rs = 32'd5; rt = 32'd6;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {63'd0, op_ready}, 64'd1);
    check("rst_stall", {63'd0, stall}, 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_core", {core_a, core_b}, 64'd0);
    check("rst_pulses", {62'd0, core_start, done}, 64'd0);
    @(negedge clk);
    op = OP_NONE; op_valid = 1'b0; resetn = 1'b0;

    run_mul("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("multu_max_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_mul("mult_neg3x5", OP_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0);
`ifdef MULDIV_SIGNED_EN
    check("mult_neg3x5_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
`else
    check("mult_neg3x5_const", {hi, lo}, 64'h0000_0004_FFFF_FFF1);
`endif
    run_mul("mult_minsq", OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0);
    check("mult_minsq_const", {hi, lo}, 64'h4000_0000_0000_0000);
    run_mul("mult_negxneg", OP_MULT, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b0);

    // Moves, reads and reserved/NONE ops in IDLE.
    @(negedge clk); op = OP_MTLO; op_valid = 1'b1; rs = 32'hCAFE_0001;
    @(negedge clk); op = OP_MFLO; rs = 32'd0;
    #1;
    check("mtlo_mflo", {32'd0, rdata}, {32'd0, 32'hCAFE_0001});
    check("mflo_nostall", {63'd0, stall}, 64'd0);
    @(negedge clk); op = 3'd7; rs = 32'hDEAD_BEEF;
    #1;
    check("rsvd_rdata", {32'd0, rdata}, 64'd0);
    @(negedge clk); op = OP_MTHI; rs = 32'h1234_5678;
    @(negedge clk); op = OP_MFHI;
    #1;
    check("rsvd_noeffect_mthi", {hi, lo}, {32'h1234_5678, 32'hCAFE_0001});
    check("mfhi_rdata", {32'd0, rdata}, {32'd0, 32'h1234_5678});
    @(negedge clk); op = OP_NONE; op_valid = 1'b0;

    run_mul("hazard", OP_MULTU, 32'd3, 32'd4, 1'b1);
    check("hazard_const", {hi, lo}, 64'h0000_0000_0000_000C);

    // Reset in the middle of a multiply.
    @(negedge clk);
    op = OP_MULTU; op_valid = 1'b1; rs = 32'd7; rt = 32'd9;
    @(posedge clk); #1;
    op = OP_NONE; op_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 resetn = 1'b1;
    #1;
    check("midrst_hilo", {hi, lo}, 64'd0);
    check("midrst_ready", {63'd0, op_ready}, 64'd1);
    check("midrst_core", {31'd0, core_start, core_a}, 64'd0);
    done_pulses = 0;
    @(negedge clk); resetn = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) done_pulses++;
    end
    check("midrst_no_done", 64'(done_pulses), 64'd0);
    check("midrst_still_idle", {63'd0, op_ready}, 64'd1);
    run_mul("after_rst", OP_MULTU, 32'd2, 32'd3, 1'b0);
    check("after_rst_const", {hi, lo}, 64'd6);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
